// File: rtl/scan_chain_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl_pkg
// Shared definitions for the scan chain sequencer: FSM state encoding and the
// default shift-count width.
// -----------------------------------------------------------------------------
package scan_chain_ctrl_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 16;
    localparam int unsigned STATE_WIDTH       = 2;

    // Sequencer states: idle/functional, shifting beats, final freeze + drain.
    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl_if
// Bundles the command, host slice streams and chain control signals of the
// scan chain sequencer.
//   cmd_en/cmd_rdy/cmd_len       : shift command handshake
//   sin_valid/sin_rdy/sin_data   : host slices into the chain head
//   sout_valid/sout_rdy/sout_data: slices returned from the chain tail
//   scan_in/scan_tail            : chain head data / chain tail data
//   scan_mode/scan_any           : shift strobe / chain under scan control
//   busy                         : sequencer not idle
// Modports: slave = sequencer, master = host + chain side.
// -----------------------------------------------------------------------------
interface scan_chain_ctrl_if #(
    parameter int unsigned SCAN_WIDTH = 1,
    parameter int unsigned CNT_WIDTH  = scan_chain_ctrl_pkg::CNT_WIDTH_DEFAULT
);

    logic                  cmd_en;
    logic                  cmd_rdy;
    logic [CNT_WIDTH-1:0]  cmd_len;
    logic                  sin_valid;
    logic                  sin_rdy;
    logic [SCAN_WIDTH-1:0] sin_data;
    logic                  sout_valid;
    logic                  sout_rdy;
    logic [SCAN_WIDTH-1:0] sout_data;
    logic [SCAN_WIDTH-1:0] scan_in;
    logic [SCAN_WIDTH-1:0] scan_tail;
    logic                  scan_mode;
    logic                  scan_any;
    logic                  busy;

    modport slave (
        input  cmd_en, cmd_len, sin_valid, sin_data, sout_rdy, scan_tail,
        output cmd_rdy, sin_rdy, sout_valid, sout_data, scan_in, scan_mode,
               scan_any, busy
    );

    modport master (
        output cmd_en, cmd_len, sin_valid, sin_data, sout_rdy, scan_tail,
        input  cmd_rdy, sin_rdy, sout_valid, sout_data, scan_in, scan_mode,
               scan_any, busy
    );

endinterface

// File: rtl/scan_chain_ctrl_scan_out_reg.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl_scan_out_reg
// One-entry pipeline register holding the slice returned from the chain tail.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   load_i  : capture data_i this cycle (a shift beat)
//   data_i  : slice from the chain tail
//   rdy_i   : downstream accepts the held slice
//   valid_o : held slice valid
//   data_o  : held slice
// A load in the same cycle as a drain keeps valid high with the new slice.
// -----------------------------------------------------------------------------
module scan_chain_ctrl_scan_out_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rdy_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next value: load wins over drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (rdy_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
// Sequencer driving the control side of a scan chain: accepts a shift command,
// freezes the chain, shifts one slice per beat (host slice in at the head,
// tail slice out to the host) and returns the chain to functional capture.
//   CLK    : clock
//   RST_N  : synchronous active-low reset
//   bus    : scan_chain_ctrl_if.slave (command, slice streams, chain control)
//   PARITY : XOR of all slices returned since the last command acceptance
//            (only when SCAN_CHAIN_CTRL_PARITY_EN is defined)
// Optional feature macro: SCAN_CHAIN_CTRL_PARITY_EN.
// -----------------------------------------------------------------------------
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_WIDTH = 1,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    scan_chain_ctrl_if.slave      bus
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    ,
    output logic [SCAN_WIDTH-1:0] PARITY
`endif
);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  cmd_rdy_q, cmd_rdy_d;
    logic                  scan_any_q, scan_any_d;
    logic                  busy_q, busy_d;
    logic                  accept_c;
    logic                  shift_c;
    logic                  sout_valid;
    logic [SCAN_WIDTH-1:0] sout_data;

    assign accept_c = bus.cmd_en && cmd_rdy_q;

    // A beat needs a host slice and room in the return register.
    assign shift_c = (state_q == ST_SHIFT) && bus.sin_valid &&
                     (!sout_valid || bus.sout_rdy);

    // State and count register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; CNT never decrements below 1, so no wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cnt_d   = bus.cmd_len;
                    state_d = (bus.cmd_len != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (shift_c) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!sout_valid || bus.sout_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state.
    always_comb begin
        cmd_rdy_d  = 1'b0;
        scan_any_d = 1'b0;
        busy_d     = 1'b0;
        if (state_d == ST_IDLE) begin
            cmd_rdy_d = 1'b1;
        end else begin
            scan_any_d = 1'b1;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cmd_rdy_q  <= 1'b1;
            scan_any_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cmd_rdy_q  <= cmd_rdy_d;
            scan_any_q <= scan_any_d;
            busy_q     <= busy_d;
        end
    end

    // Tail slice return register.
    scan_chain_ctrl_scan_out_reg #(
        .WIDTH (SCAN_WIDTH)
    ) u_scan_out_reg (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .load_i  (shift_c),
        .data_i  (bus.scan_tail),
        .rdy_i   (bus.sout_rdy),
        .valid_o (sout_valid),
        .data_o  (sout_data)
    );

`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    logic [SCAN_WIDTH-1:0] parity_q, parity_d;

    // Running XOR of returned slices, restarted on each command.
    always_comb begin
        parity_d = parity_q;
        if (accept_c) begin
            parity_d = '0;
        end else if (shift_c) begin
            parity_d = parity_q ^ bus.scan_tail;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign PARITY = parity_q;
`endif

    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.scan_any   = scan_any_q;
    assign bus.busy       = busy_q;
    assign bus.sout_valid = sout_valid;
    assign bus.sout_data  = sout_data;
    assign bus.sin_rdy    = shift_c;
    assign bus.scan_mode  = shift_c;
    assign bus.scan_in    = bus.sin_data;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_ctrl
// Self-checking bench for scan_chain_ctrl with a 4-deep model scan chain.
// Reference: a chain shifted N times returns its old contents tail-first,
// followed by the slices pushed in; the chain then holds the last DEPTH items
// of that stream.
// -----------------------------------------------------------------------------
module tb_scan_chain_ctrl;

    localparam int unsigned SW    = 1;
    localparam int unsigned CW    = 16;
    localparam int          DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    scan_chain_ctrl_if #(.SCAN_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    logic [SW-1:0] parity;
`endif

    scan_chain_ctrl #(
        .SCAN_WIDTH (SW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .bus    (bus)
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
        ,
        .PARITY (parity)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model chain: ch[0] is the head, ch[DEPTH-1] the tail.
    logic [SW-1:0] ch       [DEPTH];
    logic [SW-1:0] load_val [DEPTH];
    logic          load_req = 1'b0;
    logic [SW-1:0] obs    [$];
    logic [SW-1:0] stim   [$];
    logic [SW-1:0] stream [$];

    // Cycle monitor state.
    int            cyc            = 0;
    int            mode_cnt       = 0;
    int            mode_bad       = 0;
    int            busy_cnt       = 0;
    int            acc_cyc        = 0;
    int            last_shift_cyc = 0;
    int            any_rise_cyc   = 0;
    int            any_fall_cyc   = 0;
    logic          prev_any       = 1'b0;
    logic          s_mode         = 1'b0;
    logic          s_hs           = 1'b0;
    logic [SW-1:0] s_in           = '0;
    logic [SW-1:0] s_sd           = '0;

    int base_mode, base_obs, base_busy, base_bad;

    assign bus.scan_tail = ch[DEPTH-1];

    // Sample settled signals mid-cycle.
    always begin
        @(negedge clk);
        #2;
        s_mode = bus.scan_mode;
        s_in   = bus.scan_in;
        s_hs   = bus.sout_valid && bus.sout_rdy;
        s_sd   = bus.sout_data;
        if (bus.scan_mode) begin
            mode_cnt++;
            last_shift_cyc = cyc;
            if (!bus.sin_valid) mode_bad++;
        end
        if (bus.busy) busy_cnt++;
        if (bus.cmd_en && bus.cmd_rdy) acc_cyc = cyc;
        if (bus.scan_any && !prev_any) any_rise_cyc = cyc;
        if (!bus.scan_any && prev_any) any_fall_cyc = cyc;
        prev_any = bus.scan_any;
    end

    // Chain behaviour and returned-slice collection.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) ch[i] <= load_val[i];
        end else if (s_mode) begin
            ch[0] <= s_in;
            for (int i = 1; i < DEPTH; i++) ch[i] <= ch[i-1];
        end
        if (s_hs) obs.push_back(s_sd);
    end

    task automatic preload_random();
        for (int i = 0; i < DEPTH; i++) load_val[i] = SW'($urandom);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // tf[DEPTH-1] is the tail slice (SW == 1).
    task automatic preload_tf(input logic [DEPTH-1:0] tf);
        for (int i = 0; i < DEPTH; i++) load_val[i] = tf[i];
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic fill_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(SW'($urandom));
    endtask

    task automatic build_stream();
        stream.delete();
        for (int k = 0; k < DEPTH; k++) stream.push_back(load_val[DEPTH-1-k]);
        foreach (stim[i]) stream.push_back(stim[i]);
    endtask

    // Issue one command and drive streams until the sequencer is idle again.
    // in_pct < 0 toggles SIN_VALID every other cycle.
    task automatic run_cmd(input int len, input int in_pct, input int rdy_pct,
                           output bit to);
        int n;
        int k;
        base_mode = mode_cnt;
        base_obs  = obs.size();
        base_busy = busy_cnt;
        base_bad  = mode_bad;
        @(negedge clk);
        bus.cmd_en    = 1'b1;
        bus.cmd_len   = CW'(len);
        bus.sin_valid = 1'b0;
        bus.sout_rdy  = 1'b0;
        @(negedge clk);
        bus.cmd_en = 1'b0;
        n  = 0;
        to = 1'b0;
        while (bus.cmd_rdy !== 1'b1) begin
            k = mode_cnt - base_mode;
            bus.sin_valid = (k < len) &&
                            ((in_pct < 0) ? (n[0] == 1'b0)
                                          : (int'($urandom_range(99)) < in_pct));
            bus.sin_data  = (k < stim.size()) ? stim[k] : SW'($urandom);
            bus.sout_rdy  = int'($urandom_range(99)) < rdy_pct;
            @(negedge clk);
            n++;
            if (n > 40 + len * 20) begin
                to = 1'b1;
                break;
            end
        end
        bus.sin_valid = 1'b0;
        bus.sout_rdy  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.scan_any !== 1'b0) begin errors++; $display("FAIL reset_scan_any: got %b expected 0", bus.scan_any); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy: got %b expected 1", bus.cmd_rdy); end
        checks++; if (bus.sout_valid !== 1'b0) begin errors++; $display("FAIL reset_sout_valid: got %b expected 0", bus.sout_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.sout_data !== '0) begin errors++; $display("FAIL reset_sout_data: got %h expected 0", bus.sout_data); end
        checks++; if (bus.scan_mode !== 1'b0 || bus.sin_rdy !== 1'b0) begin errors++; $display("FAIL reset_strobes: got mode=%b rdy=%b expected 0/0", bus.scan_mode, bus.sin_rdy); end
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
        checks++; if (parity !== '0) begin errors++; $display("FAIL reset_parity: got %h expected 0", parity); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        bit            to;
        logic [3:0]    exp_out = 4'b0110;
        logic [3:0]    exp_chain = 4'b1101;
        logic [3:0]    head_first;
        preload_tf(4'b0110);
        stim.delete();
        stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
        run_cmd(4, 100, 100, to);
        checks++; if (to) begin errors++; $display("FAIL dir_timeout: got timeout expected idle"); end
        checks++; if (obs.size() - base_obs != 4) begin errors++; $display("FAIL dir_beats: got %0d expected 4", obs.size() - base_obs); end
        for (int j = 0; j < 4; j++) begin
            if (obs.size() > base_obs + j) begin
                checks++;
                if (obs[base_obs+j] !== exp_out[3-j]) begin errors++; $display("FAIL dir_sout%0d: got %b expected %b", j, obs[base_obs+j], exp_out[3-j]); end
            end
        end
        head_first = {ch[0], ch[1], ch[2], ch[3]};
        checks++; if (head_first !== exp_chain) begin errors++; $display("FAIL dir_chain: got %b expected %b", head_first, exp_chain); end
        checks++; if (any_rise_cyc != acc_cyc + 1) begin errors++; $display("FAIL dir_any_rise: got %0d expected %0d", any_rise_cyc, acc_cyc + 1); end
        checks++; if (last_shift_cyc != acc_cyc + 4) begin errors++; $display("FAIL dir_last_shift: got %0d expected %0d", last_shift_cyc, acc_cyc + 4); end
        checks++; if (any_fall_cyc != last_shift_cyc + 2) begin errors++; $display("FAIL dir_any_fall: got %0d expected %0d", any_fall_cyc, last_shift_cyc + 2); end
        checks++; if (mode_cnt - base_mode != 4) begin errors++; $display("FAIL dir_pulses: got %0d expected 4", mode_cnt - base_mode); end
    endtask

    task automatic test_backpressure();
        int k;
        int n;
        preload_random();
        fill_stim(3);
        build_stream();
        base_mode = mode_cnt;
        base_obs  = obs.size();
        @(negedge clk);
        bus.cmd_en = 1'b1; bus.cmd_len = CW'(3); bus.sin_valid = 1'b0; bus.sout_rdy = 1'b0;
        @(negedge clk);
        bus.cmd_en = 1'b0; bus.sin_valid = 1'b1; bus.sout_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            k = mode_cnt - base_mode;
            bus.sin_data = (k < 3) ? stim[k] : '0;
            @(negedge clk);
        end
        checks++; if (mode_cnt - base_mode != 1) begin errors++; $display("FAIL bp_stall_pulses: got %0d expected 1", mode_cnt - base_mode); end
        checks++; if (bus.scan_mode !== 1'b0) begin errors++; $display("FAIL bp_scan_mode: got %b expected 0", bus.scan_mode); end
        checks++; if (bus.sout_valid !== 1'b1) begin errors++; $display("FAIL bp_sout_valid: got %b expected 1", bus.sout_valid); end
        checks++; if (bus.sout_data !== stream[0]) begin errors++; $display("FAIL bp_sout_data: got %b expected %b", bus.sout_data, stream[0]); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (ch[DEPTH-1-i] !== stream[1+i]) begin errors++; $display("FAIL bp_held_chain%0d: got %b expected %b", i, ch[DEPTH-1-i], stream[1+i]); end
        end
        bus.sout_rdy = 1'b1;
        n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 40) begin
            k = mode_cnt - base_mode;
            bus.sin_valid = (k < 3);
            bus.sin_data  = (k < 3) ? stim[k] : '0;
            @(negedge clk);
            n++;
        end
        bus.sin_valid = 1'b0; bus.sout_rdy = 1'b0;
        @(negedge clk);
        checks++; if (n >= 40) begin errors++; $display("FAIL bp_timeout: got %0d cycles expected < 40", n); end
        checks++; if (obs.size() - base_obs != 3) begin errors++; $display("FAIL bp_beats: got %0d expected 3", obs.size() - base_obs); end
        for (int j = 0; j < 3; j++) begin
            if (obs.size() > base_obs + j) begin
                checks++; if (obs[base_obs+j] !== stream[j]) begin errors++; $display("FAIL bp_sout%0d: got %b expected %b", j, obs[base_obs+j], stream[j]); end
            end
        end
        checks++; if (mode_cnt - base_mode != 3) begin errors++; $display("FAIL bp_pulses: got %0d expected 3", mode_cnt - base_mode); end
    endtask

    task automatic test_toggle();
        bit to;
        preload_random();
        fill_stim(6);
        build_stream();
        run_cmd(6, -1, 100, to);
        checks++; if (to) begin errors++; $display("FAIL tog_timeout: got timeout expected idle"); end
        checks++; if (mode_cnt - base_mode != 6) begin errors++; $display("FAIL tog_pulses: got %0d expected 6", mode_cnt - base_mode); end
        checks++; if (mode_bad - base_bad != 0) begin errors++; $display("FAIL tog_mode_no_valid: got %0d expected 0", mode_bad - base_bad); end
        for (int j = 0; j < 6; j++) begin
            if (obs.size() > base_obs + j) begin
                checks++; if (obs[base_obs+j] !== stream[j]) begin errors++; $display("FAIL tog_sout%0d: got %b expected %b", j, obs[base_obs+j], stream[j]); end
            end
        end
    endtask

    task automatic test_zero_len();
        bit to;
        preload_random();
        stim.delete();
        run_cmd(0, 100, 100, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: got timeout expected idle"); end
        checks++; if (busy_cnt - base_busy != 1) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 1", busy_cnt - base_busy); end
        checks++; if (mode_cnt - base_mode != 0) begin errors++; $display("FAIL zero_pulses: got %0d expected 0", mode_cnt - base_mode); end
        checks++; if (obs.size() - base_obs != 0) begin errors++; $display("FAIL zero_beats: got %0d expected 0", obs.size() - base_obs); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (ch[i] !== load_val[i]) begin errors++; $display("FAIL zero_chain%0d: got %b expected %b", i, ch[i], load_val[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        preload_random();
        base_mode = mode_cnt;
        @(negedge clk);
        bus.cmd_en = 1'b1; bus.cmd_len = CW'(5); bus.sin_valid = 1'b0; bus.sout_rdy = 1'b0;
        @(negedge clk);
        bus.cmd_en = 1'b0; bus.sin_valid = 1'b1; bus.sin_data = SW'($urandom); bus.sout_rdy = 1'b1;
        n = 0;
        while (mode_cnt - base_mode < 2 && n < 20) begin
            @(negedge clk);
            bus.sin_data = SW'($urandom);
            n++;
        end
        rst_n = 1'b0;
        bus.sin_valid = 1'b0;
        @(negedge clk);
        checks++; if (mode_cnt - base_mode != 2) begin errors++; $display("FAIL rst_mid_pulses: got %0d expected 2", mode_cnt - base_mode); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.scan_any !== 1'b0) begin errors++; $display("FAIL rst_mid_scan_any: got %b expected 0", bus.scan_any); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_rdy: got %b expected 1", bus.cmd_rdy); end
        checks++; if (bus.sout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_sout_valid: got %b expected 0", bus.sout_valid); end
        rst_n = 1'b1;
        bus.sout_rdy = 1'b0;
        @(negedge clk);
    endtask

`ifdef SCAN_CHAIN_CTRL_PARITY_EN
    task automatic test_parity();
        bit to;
        preload_tf(4'b1110);
        fill_stim(4);
        run_cmd(4, 100, 100, to);
        checks++; if (parity !== 1'b1) begin errors++; $display("FAIL parity_1110: got %b expected 1", parity); end
    endtask
`endif

    task automatic test_random();
        bit            to;
        int            len;
        logic [SW-1:0] p;
        for (int it = 0; it < 15; it++) begin
            len = int'($urandom_range(10, 1));
            preload_random();
            fill_stim(len);
            build_stream();
            run_cmd(len, int'($urandom_range(100, 40)), int'($urandom_range(100, 30)), to);
            checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: got timeout expected idle", it); end
            checks++; if (obs.size() - base_obs != len) begin errors++; $display("FAIL rnd%0d_beats: got %0d expected %0d", it, obs.size() - base_obs, len); end
            for (int j = 0; j < len; j++) begin
                if (obs.size() > base_obs + j) begin
                    checks++; if (obs[base_obs+j] !== stream[j]) begin errors++; $display("FAIL rnd%0d_sout%0d: got %b expected %b", it, j, obs[base_obs+j], stream[j]); end
                end
            end
            checks++; if (mode_cnt - base_mode != len) begin errors++; $display("FAIL rnd%0d_pulses: got %0d expected %0d", it, mode_cnt - base_mode, len); end
            checks++; if (mode_bad - base_bad != 0) begin errors++; $display("FAIL rnd%0d_mode_no_valid: got %0d expected 0", it, mode_bad - base_bad); end
            for (int k = 0; k < DEPTH; k++) begin
                checks++; if (ch[DEPTH-1-k] !== stream[len+k]) begin errors++; $display("FAIL rnd%0d_chain%0d: got %b expected %b", it, k, ch[DEPTH-1-k], stream[len+k]); end
            end
            checks++; if (bus.sout_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle_sout_valid: got %b expected 0", it, bus.sout_valid); end
            p = '0;
            for (int j = 0; j < len; j++) p = p ^ stream[j];
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
            checks++; if (parity !== p) begin errors++; $display("FAIL rnd%0d_parity: got %b expected %b", it, parity, p); end
`endif
        end
    endtask

    initial begin
        bus.cmd_en    = 1'b0;
        bus.cmd_len   = '0;
        bus.sin_valid = 1'b0;
        bus.sin_data  = '0;
        bus.sout_rdy  = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_toggle();
        test_zero_len();
        test_reset_mid();
`ifdef SCAN_CHAIN_CTRL_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
